// File: rtl/rs_bm_sequencer.sv
// rs_bm_sequencer: buffers syndrome sets, launches the S_to_Sigma Berlekamp-Massey engine with
// a one-cycle bm_signal pulse, captures sigma on bm_ready and hands it downstream over
// valid/ready. Launches are spaced by at least MIN_GAP cycles; a silent engine is flagged after
// TIMEOUT cycles with a sticky err_timeout and a substituted sigma of 1.
// Optional feature macro: RS_ZERO_BYPASS_EN -- all-zero syndrome sets skip the engine and emit
// sigma = 1 directly. Left undefined, every set is launched.
module rs_bm_sequencer #(
    parameter int unsigned SYM_W      = 8,
    parameter int unsigned NSYN       = 6,
    parameter int unsigned NSIG       = 4,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MIN_GAP    = 16,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NSYN*SYM_W-1:0]  in_syn,
    output logic                   bm_signal,
    output logic [NSYN*SYM_W-1:0]  bm_w,
    input  logic                   bm_ready,
    input  logic [NSIG*SYM_W-1:0]  bm_sigma,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NSIG*SYM_W-1:0]  out_sigma,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int unsigned SynW  = NSYN * SYM_W;
    localparam int unsigned SigW  = NSIG * SYM_W;
    localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned GapW  = $clog2(MIN_GAP + 1);
    localparam int unsigned WaitW = $clog2(TIMEOUT + 1);

    localparam logic [SigW-1:0]  SigmaUnit = SigW'(1);
    localparam logic [GapW-1:0]  GapFull   = GapW'(MIN_GAP);
    localparam logic [WaitW-1:0] WaitMax   = WaitW'(TIMEOUT);
    localparam logic [WaitW-1:0] WaitLive  = WaitW'(2);
    localparam logic [CntW-1:0]  CntFull   = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0]  PtrLast   = PtrW'(FIFO_DEPTH - 1);

`ifdef RS_ZERO_BYPASS_EN
    localparam bit ZeroBypass = 1'b1;
`else
    localparam bit ZeroBypass = 1'b0;
`endif

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWait,
        StOut
    } state_e;

    state_e            state_q, state_d;
    logic [SynW-1:0]   mem_q [FIFO_DEPTH];
    logic [SynW-1:0]   mem_d [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [GapW-1:0]   gap_q, gap_d;
    logic [WaitW-1:0]  wait_q, wait_d;
    logic              bm_signal_q, bm_signal_d;
    logic [SynW-1:0]   bm_w_q, bm_w_d;
    logic              out_valid_q, out_valid_d;
    logic [SigW-1:0]   out_sigma_q, out_sigma_d;
    logic              err_q, err_d;

    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic [SynW-1:0]   head;
    logic              head_bypass;

    assign fifo_empty  = (cnt_q == '0);
    assign fifo_full   = (cnt_q == CntFull);
    assign push        = in_valid && !fifo_full;
    assign head        = mem_q[rd_ptr_q];
    assign head_bypass = ZeroBypass && (head == '0);

    // FIFO next state: storage write, pointer wrap and occupancy
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = in_syn;
            wr_ptr_d        = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Sequencer FSM next state, launch spacing and registered engine/downstream outputs
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        bm_signal_d = 1'b0;
        bm_w_d      = bm_w_q;
        out_valid_d = out_valid_q;
        out_sigma_d = out_sigma_q;
        err_d       = err_q;
        wait_d      = wait_q;
        gap_d       = (gap_q == GapFull) ? gap_q : gap_q + 1'b1;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && head_bypass) begin
                    // Zero syndromes mean no errors: sigma(x) = 1 without using the engine.
                    pop         = 1'b1;
                    out_sigma_d = SigmaUnit;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else if (!fifo_empty && (gap_q == GapFull)) begin
                    pop         = 1'b1;
                    bm_w_d      = head;
                    bm_signal_d = 1'b1;
                    gap_d       = '0;
                    state_d     = StLaunch;
                end
            end
            StLaunch: begin
                wait_d  = WaitW'(1);
                state_d = StWait;
            end
            StWait: begin
                // First WAIT cycle ignores bm_ready: it may still be high from the last result.
                if ((wait_q >= WaitLive) && bm_ready) begin
                    out_sigma_d = bm_sigma;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else if (wait_q >= WaitMax) begin
                    err_d       = 1'b1;
                    out_sigma_d = SigmaUnit;
                    out_valid_d = 1'b1;
                    state_d     = StOut;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StOut: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Syndrome storage needs no reset: occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            gap_q       <= GapFull;
            wait_q      <= '0;
            bm_signal_q <= 1'b0;
            bm_w_q      <= '0;
            out_valid_q <= 1'b0;
            out_sigma_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            gap_q       <= gap_d;
            wait_q      <= wait_d;
            bm_signal_q <= bm_signal_d;
            bm_w_q      <= bm_w_d;
            out_valid_q <= out_valid_d;
            out_sigma_q <= out_sigma_d;
            err_q       <= err_d;
        end
    end

    assign in_ready    = !fifo_full;
    assign bm_signal   = bm_signal_q;
    assign bm_w        = bm_w_q;
    assign out_valid   = out_valid_q;
    assign out_sigma   = out_sigma_q;
    assign err_timeout = err_q;
    assign busy        = (state_q != StIdle) || !fifo_empty;

endmodule
